// File: rtl/gf2_digit_serial_mult_52bit.sv
// Digit-serial carry-less (GF(2)[x]) multiplier: DIGIT bits of b per cycle,
// accumulating a(x)*b(x) into a 2*WIDTH-1 bit product with a valid/ready handshake.
module gf2_digit_serial_mult_52bit #(
    parameter int WIDTH = 52,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-2:0] out_data,
    output logic               busy
);

    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int PW   = NDIG * DIGIT;
    localparam int OW   = 2 * WIDTH - 1;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [OW-1:0]   acc_r;
    logic [OW-1:0]   a_sh_r;
    logic [PW-1:0]   b_sh_r;
    logic [OW-1:0]   out_data_r;
    logic [OW-1:0]   prod_s;
    logic            load_s;
    logic            step_s;
    logic            last_s;
    logic            in_ready_s;

    // One digit slice: a is pre-shifted by cnt*DIGIT, b pre-shifted down so the current digit sits at [DIGIT-1:0].
    always_comb begin
        prod_s = '0;
        for (int j = 0; j < DIGIT; j++) begin
            prod_s = prod_s ^ ((a_sh_r << j) & {OW{b_sh_r[j]}});
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = (cnt_r == LAST);
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    load_s       = 1'b1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                in_ready_s = out_ready;
                if (out_ready && in_valid) begin
                    load_s       = 1'b1;
                    state_next_s = BUSY;
                end else if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand shifters, accumulator and product output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            acc_r      <= '0;
            a_sh_r     <= '0;
            b_sh_r     <= '0;
            out_data_r <= '0;
        end else begin
            if (load_s) begin
                a_sh_r <= OW'(in_a);
                b_sh_r <= PW'(in_b);
                acc_r  <= '0;
                cnt_r  <= '0;
            end else if (step_s) begin
                acc_r  <= acc_r ^ prod_s;
                a_sh_r <= a_sh_r << DIGIT;
                b_sh_r <= b_sh_r >> DIGIT;
                cnt_r  <= cnt_r + CW'(1);
            end
            // Product is captured once, so it stays put until the next completion.
            if (step_s && last_s) begin
                out_data_r <= acc_r ^ prod_s;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == BUSY);
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_gf2_digit_serial_mult_52bit.sv
// Directed/table-driven bench for the digit-serial carry-less multiplier,
// including handshake corner cases and a DIGIT sweep on extra instances.
module tb_gf2_digit_serial_mult_52bit;

    localparam int W  = 52;
    localparam int OW = 103;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  in_a, in_b;
    logic [OW-1:0] out_data;

    logic          sw_in_valid;
    logic [W-1:0]  sw_in_a, sw_in_b;
    logic          sw_out_ready;
    logic [2:0]    sw_in_ready, sw_out_valid, sw_busy;
    logic [OW-1:0] sw_out_data [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gf2_digit_serial_mult_52bit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy));

    gf2_digit_serial_mult_52bit #(.WIDTH(52), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[0]),
        .in_a(sw_in_a), .in_b(sw_in_b), .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready),
        .out_data(sw_out_data[0]), .busy(sw_busy[0]));

    gf2_digit_serial_mult_52bit #(.WIDTH(52), .DIGIT(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[1]),
        .in_a(sw_in_a), .in_b(sw_in_b), .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready),
        .out_data(sw_out_data[1]), .busy(sw_busy[1]));

    gf2_digit_serial_mult_52bit #(.WIDTH(52), .DIGIT(52)) u_d52 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[2]),
        .in_a(sw_in_a), .in_b(sw_in_b), .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready),
        .out_data(sw_out_data[2]), .busy(sw_busy[2]));

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [OW-1:0] exp;
        string         name;
    } vec_t;

    vec_t vecs [8];

    // Bit-serial reference carry-less product.
    function automatic logic [OW-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r = r ^ (OW'(a) << i);
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [OW-1:0] exp, input string nm);
        int cyc;
        int nbusy;
        check({nm, " in_ready"}, OW'(in_ready), OW'(1));
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = ~a; in_b = ~b;
        cyc = 0; nbusy = 0;
        while (!out_valid && cyc < 100) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, " latency"}, OW'(cyc), OW'(13));
        check({nm, " busy_cycles"}, OW'(nbusy), OW'(13));
        check({nm, " data"}, out_data, exp);
        @(posedge clk); #1;
        check({nm, " valid_drop"}, OW'(out_valid), OW'(0));
    endtask

    task automatic sweep(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat [3];
        logic [OW-1:0] d [3];
        int exp_lat [3];
        exp_lat = '{52, 11, 1};
        lat = '{0, 0, 0};
        d = '{'0, '0, '0};
        sw_in_a = a; sw_in_b = b; sw_in_valid = 1'b1;
        @(posedge clk); #1;
        sw_in_valid = 1'b0;
        for (int c = 0; c <= 60; c++) begin
            for (int g = 0; g < 3; g++) begin
                if (sw_out_valid[g] && lat[g] == 0) begin
                    lat[g] = c;
                    d[g] = sw_out_data[g];
                end
            end
            @(posedge clk); #1;
        end
        for (int g = 0; g < 3; g++) begin
            check($sformatf("sweep%0d latency", g), OW'(lat[g]), OW'(exp_lat[g]));
            check($sformatf("sweep%0d data", g), d[g], clmul(a, b));
        end
    endtask

    initial begin
        logic [W-1:0]  ones;
        logic [OW-1:0] even;
        logic [OW-1:0] low52;
        logic [W-1:0]  ba [20];
        logic [W-1:0]  bb [20];
        logic [OW-1:0] q [$];
        int idx, got, cyc, last;
        logic acc_now, xfer_now;

        ones = '1;
        even = '0;
        for (int i = 0; i < OW; i += 2) even[i] = 1'b1;
        low52 = OW'(ones);

        vecs[0] = '{52'h3, 52'h3, 103'h5, "clmul_3x3"};
        vecs[1] = '{52'h8000000000000, 52'h8000000000000, {1'b1, 102'h0}, "top_bits"};
        vecs[2] = '{ones, 52'h1, low52, "ones_x_1"};
        vecs[3] = '{ones, ones, even, "ones_x_ones"};
        vecs[4] = '{52'h0, 52'h123456789ABCD, 103'h0, "a_zero"};
        vecs[5] = '{52'hFEDCBA9876543, 52'h0, 103'h0, "b_zero"};
        vecs[6] = '{52'h5, 52'h7, 103'h1B, "clmul_5x7"};
        vecs[7] = '{52'hB, 52'h9, 103'h53, "clmul_bx9"};

        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        sw_in_valid = 1'b0; sw_in_a = '0; sw_in_b = '0; sw_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", OW'(in_ready), OW'(1));
        check("rst out_valid", OW'(out_valid), OW'(0));
        check("rst busy", OW'(busy), OW'(0));
        check("rst out_data", out_data, '0);
        check("rst sweep in_ready", OW'(sw_in_ready), OW'(3'b111));
        check("rst sweep busy", OW'(sw_busy), OW'(3'b000));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].name);
        end

        // Backpressure: result held, new operands refused until the transfer.
        out_ready = 1'b0;
        in_a = 52'hB; in_b = 52'h9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp latency", OW'(cyc), OW'(13));
        for (int k = 0; k < 5; k++) begin
            check("bp valid_hold", OW'(out_valid), OW'(1));
            check("bp data_hold", out_data, 103'h53);
            in_valid = k[0];
            in_a = 52'h3; in_b = 52'h3;
            check("bp in_ready", OW'(in_ready), OW'(0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp in_ready_follow", OW'(in_ready), OW'(1));
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check("bp single_xfer", OW'({out_valid, busy}), OW'(0));
            @(posedge clk); #1;
        end

        // Back-to-back: in_valid held high across 20 operand pairs.
        for (int i = 0; i < 20; i++) begin
            ba[i] = W'({$urandom(), $urandom()});
            bb[i] = W'({$urandom(), $urandom()});
        end
        idx = 0; got = 0; cyc = 0; last = 0;
        in_a = ba[0]; in_b = bb[0]; in_valid = 1'b1;
        while (got < 20 && cyc < 1000) begin
            acc_now  = in_valid && in_ready;
            xfer_now = out_valid && out_ready;
            if (xfer_now) begin
                if (q.size() > 0) begin
                    check($sformatf("b2b data%0d", got), out_data, q.pop_front());
                end else begin
                    check("b2b unexpected_result", OW'(1), OW'(0));
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                q.push_back(clmul(ba[idx], bb[idx]));
                if (idx > 0) check("b2b spacing", OW'(cyc - last), OW'(14));
                last = cyc;
                idx++;
                if (idx < 20) begin
                    in_a = ba[idx]; in_b = bb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b results", OW'(got), OW'(20));
        check("b2b leftover", OW'(q.size()), OW'(0));
        @(posedge clk); #1;

        // Reset in the middle of a computation.
        in_a = 52'h5; in_b = 52'h7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst busy_before", OW'(busy), OW'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst out_valid", OW'(out_valid), OW'(0));
        check("midrst busy", OW'(busy), OW'(0));
        check("midrst in_ready", OW'(in_ready), OW'(1));
        check("midrst out_data", out_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(52'h2, 52'h3, 103'h6, "after_rst");

        // DIGIT sweep on the extra instances.
        sweep(ones, ones);
        sweep(52'hABCDEF0123457, 52'h8000000000001);
        sweep(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
